// File: rtl/bin_to_bcd_module.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Out-of-range operands saturate to all nines and raise Overflow_Sig.
module bin_to_bcd_module #(
    parameter logic [19:0] MAX_VALUE = 20'd999999
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start_Sig,
    input  logic [19:0] Binary_Data,
    output logic [23:0] Number_Sig,
    output logic        Done_Sig,
    output logic        Busy_Sig,
    output logic        Overflow_Sig
);

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t      state;
    logic [19:0] shift_reg;
    logic [23:0] scratch;
    logic [4:0]  count;
    logic [23:0] adjusted;
    logic [43:0] shifted;

    // One double-dabble step: correct digits >= 5, then shift scratch:operand left.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < 6; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                adjusted[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
        shifted = {adjusted, shift_reg} << 1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            shift_reg    <= '0;
            scratch      <= '0;
            count        <= '0;
            Number_Sig   <= '0;
            Done_Sig     <= 1'b0;
            Busy_Sig     <= 1'b0;
            Overflow_Sig <= 1'b0;
        end else begin
            Done_Sig <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start_Sig) begin
                        if (Binary_Data > MAX_VALUE) begin
                            Number_Sig   <= 24'h999999;
                            Overflow_Sig <= 1'b1;
                            Done_Sig     <= 1'b1;
                        end else begin
                            shift_reg    <= Binary_Data;
                            scratch      <= '0;
                            count        <= '0;
                            Overflow_Sig <= 1'b0;
                            Busy_Sig     <= 1'b1;
                            state        <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    scratch   <= shifted[43:20];
                    shift_reg <= shifted[19:0];
                    count     <= count + 5'd1;
                    // The 20th step publishes its own result, so Done lands on this edge.
                    if (count == 5'd19) begin
                        Number_Sig <= shifted[43:20];
                        Done_Sig   <= 1'b1;
                        Busy_Sig   <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_module.sv
// Self-checking bench for bin_to_bcd_module: directed scenarios plus random
// operands compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_module;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start_Sig = 1'b0;
    logic [19:0] Binary_Data = '0;
    logic [23:0] Number_Sig;
    logic        Done_Sig;
    logic        Busy_Sig;
    logic        Overflow_Sig;

    int total = 0;
    int bad = 0;

    bin_to_bcd_module dut (
        .CLK         (CLK),
        .RST         (RST),
        .Start_Sig   (Start_Sig),
        .Binary_Data (Binary_Data),
        .Number_Sig  (Number_Sig),
        .Done_Sig    (Done_Sig),
        .Busy_Sig    (Busy_Sig),
        .Overflow_Sig(Overflow_Sig)
    );

    always #5 CLK = ~CLK;

    // Decimal digits by division; out-of-range operands saturate.
    function automatic logic [23:0] ref_bcd(input int v);
        logic [23:0] r;
        int p;
        if (v > 999999) return 24'h999999;
        r = '0;
        p = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit digits_valid(input logic [23:0] n);
        for (int i = 0; i < 6; i++) begin
            if (n[i*4 +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Launches one conversion and observes 30 cycles; k=0 is the cycle after the accepting edge.
    task automatic run_conv(input logic [19:0] v, output int latency, output int busy_cnt,
                            output int done_cnt, output logic [23:0] num, output logic ovf,
                            output bit held_ok, output bit digits_ok);
        logic [23:0] prev;
        prev      = Number_Sig;
        latency   = -1;
        busy_cnt  = 0;
        done_cnt  = 0;
        num       = 'x;
        ovf       = 1'bx;
        held_ok   = 1'b1;
        digits_ok = 1'b1;
        Start_Sig   = 1'b1;
        Binary_Data = v;
        tick();
        Start_Sig   = 1'b0;
        Binary_Data = 20'($urandom);
        for (int k = 0; k < 30; k++) begin
            if (Busy_Sig) busy_cnt++;
            if (!digits_valid(Number_Sig)) digits_ok = 1'b0;
            if (Done_Sig) begin
                done_cnt++;
                if (latency < 0) latency = k;
                num  = Number_Sig;
                ovf  = Overflow_Sig;
                prev = Number_Sig;
            end else if (Number_Sig !== prev) begin
                held_ok = 1'b0;
            end
            tick();
        end
    endtask

    task automatic check_conv(input string name, input int v);
        int latency, busy_cnt, done_cnt;
        logic [23:0] num;
        logic ovf;
        bit held_ok, digits_ok;
        bit over;
        over = (v > 999999);
        run_conv(20'(v), latency, busy_cnt, done_cnt, num, ovf, held_ok, digits_ok);
        total++;
        if (num !== ref_bcd(v)) begin
            bad++;
            $display("[TB] FAIL %s number v=%0d got=%h exp=%h", name, v, num, ref_bcd(v));
        end
        total++;
        if (ovf !== over) begin
            bad++;
            $display("[TB] FAIL %s overflow v=%0d got=%b exp=%b", name, v, ovf, over);
        end
        total++;
        if (latency != (over ? 0 : 20)) begin
            bad++;
            $display("[TB] FAIL %s latency v=%0d got=%0d exp=%0d", name, v, latency, over ? 0 : 20);
        end
        total++;
        if (busy_cnt != (over ? 0 : 20)) begin
            bad++;
            $display("[TB] FAIL %s busy_cycles v=%0d got=%0d exp=%0d", name, v, busy_cnt, over ? 0 : 20);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("[TB] FAIL %s done_pulses v=%0d got=%0d exp=1", name, v, done_cnt);
        end
        total++;
        if (!held_ok || !digits_ok) begin
            bad++;
            $display("[TB] FAIL %s hold_or_digits v=%0d got held=%b digits=%b exp 1 1", name, v, held_ok, digits_ok);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        Start_Sig = 1'b1;
        Binary_Data = 20'd77;
        tick();
        tick();
        total++;
        if ({Number_Sig, Done_Sig, Busy_Sig, Overflow_Sig} !== 27'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got num=%h d=%b b=%b o=%b exp all 0",
                     Number_Sig, Done_Sig, Busy_Sig, Overflow_Sig);
        end
        RST = 1'b0;
        tick();
        total++;
        if (Busy_Sig !== 1'b1) begin
            bad++;
            $display("[TB] FAIL first_start_accept busy got=%b exp=1", Busy_Sig);
        end
        Start_Sig = 1'b0;
        for (int k = 0; k < 25; k++) tick();
        total++;
        if (Number_Sig !== 24'h000077) begin
            bad++;
            $display("[TB] FAIL first_start_result got=%h exp=000077", Number_Sig);
        end
    endtask

    task automatic test_basic();
        check_conv("basic_123456", 123456);
    endtask

    task automatic test_corners();
        check_conv("corner_0", 0);
        check_conv("corner_999999", 999999);
        check_conv("corner_9", 9);
    endtask

    task automatic test_overflow();
        check_conv("overflow_1000000", 1000000);
        check_conv("after_overflow_42", 42);
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        Start_Sig = 1'b1;
        Binary_Data = 20'd654321;
        tick();
        Start_Sig = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 4) begin
                Start_Sig = 1'b1;
                Binary_Data = 20'd1;
            end else begin
                Start_Sig = 1'b0;
            end
            if (Done_Sig) begin
                done_cnt++;
                total++;
                if (Number_Sig !== 24'h654321) begin
                    bad++;
                    $display("[TB] FAIL ignore_start result got=%h exp=654321", Number_Sig);
                end
            end
            tick();
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("[TB] FAIL ignore_start done_pulses got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [23:0] r1, r2;
        t1 = -1;
        t2 = -1;
        r1 = 'x;
        r2 = 'x;
        Start_Sig = 1'b1;
        Binary_Data = 20'd500;
        tick();
        Binary_Data = 20'd777;
        for (int k = 0; k < 60 && t2 < 0; k++) begin
            if (Done_Sig) begin
                if (t1 < 0) begin
                    t1 = k;
                    r1 = Number_Sig;
                end else begin
                    t2 = k;
                    r2 = Number_Sig;
                    Start_Sig = 1'b0;
                end
            end
            tick();
        end
        Start_Sig = 1'b0;
        for (int k = 0; k < 25; k++) tick();
        total++;
        if (r1 !== ref_bcd(500) || r2 !== ref_bcd(777)) begin
            bad++;
            $display("[TB] FAIL back_to_back results got=%h,%h exp=%h,%h", r1, r2, ref_bcd(500), ref_bcd(777));
        end
        total++;
        if (t1 < 0 || t2 < 0 || (t2 - t1) != 21) begin
            bad++;
            $display("[TB] FAIL back_to_back spacing got t1=%0d t2=%0d exp gap=21", t1, t2);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        Start_Sig = 1'b1;
        Binary_Data = 20'd271828;
        tick();
        Start_Sig = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++;
        if ({Number_Sig, Done_Sig, Busy_Sig, Overflow_Sig} !== 27'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid outputs got num=%h d=%b b=%b o=%b exp all 0",
                     Number_Sig, Done_Sig, Busy_Sig, Overflow_Sig);
        end
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (Done_Sig || Busy_Sig) done_cnt++;
            tick();
        end
        total++;
        if (done_cnt != 0) begin
            bad++;
            $display("[TB] FAIL reset_mid activity got=%0d cycles exp=0", done_cnt);
        end
        check_conv("after_reset_31415", 31415);
    endtask

    task automatic test_random();
        int v;
        for (int n = 0; n < 20; n++) begin
            if (n % 5 == 4) v = int'($urandom_range(1000000, 1048575));
            else v = int'($urandom_range(0, 999999));
            check_conv("random", v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
